rtc_countdown_timer: RTL and testbench

//  BCD count-down timer for the RTC core: the down-counting counterpart of the

---
 rtl/rtc_countdown_timer.sv | 152 +++++++++++++++
 tb/tb_rtc_countdown_timer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_countdown_timer.sv
// BCD HH:MM:SS.hh count-down timer driven by the shared RTC clock step.
// Expiry stops the count (or reloads it) and raises a one-cycle interrupt plus a sticky alarm.
module rtc_countdown_timer #(
  parameter bit OPT_AUTORELOAD = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_ckstep,
  input  logic        i_load,
  input  logic [30:0] i_load_value,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_ack,
  output logic [30:0] o_value,
  output logic        o_running,
  output logic        o_alarm,
  output logic        o_int
);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [30:0] VALUE_MASK = 31'h7F7F_7FFF;

  function automatic logic [4:0] dig_dec(input logic [3:0] d, input logic [3:0] wrap,
                                         input logic bin);
    logic [4:0] r;
    if (!bin) begin
      r = {1'b0, d};
    end else if (d == 4'd0) begin
      r = {1'b1, wrap};
    end else begin
      r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  // Whole-counter decrement; bits 15 and 23 stay zero, 10hr is a plain binary field.
  function automatic logic [30:0] bcd_dec(input logic [30:0] v);
    logic [30:0] r;
    logic [4:0]  t;
    logic        b;
    r = 31'h0;
    t = dig_dec(v[3:0], 4'd9, 1'b1);          r[3:0]   = t[3:0]; b = t[4];
    t = dig_dec(v[7:4], 4'd9, b);             r[7:4]   = t[3:0]; b = t[4];
    t = dig_dec(v[11:8], 4'd9, b);            r[11:8]  = t[3:0]; b = t[4];
    t = dig_dec({1'b0, v[14:12]}, 4'd5, b);   r[14:12] = t[2:0]; b = t[4];
    t = dig_dec(v[19:16], 4'd9, b);           r[19:16] = t[3:0]; b = t[4];
    t = dig_dec({1'b0, v[22:20]}, 4'd5, b);   r[22:20] = t[2:0]; b = t[4];
    t = dig_dec(v[27:24], 4'd9, b);           r[27:24] = t[3:0]; b = t[4];
    r[30:28] = b ? (v[30:28] - 3'd1) : v[30:28];
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [30:0] cnt_q, cnt_d;
  logic [30:0] rel_q, rel_d;
  logic [30:0] dec_q;
  logic        dec_vld_q;
  logic        pend_q, pend_d;
  logic        alarm_q, alarm_d;
  logic        int_q, int_d;
  logic [47:0] step_q, step_d;
  logic [47:0] acc_q, acc_d;
  logic [48:0] acc_sum_s;
  logic        tick_s;
  logic        want_s;
  logic [30:0] load_val_s;

  assign step_d     = {16'h0, i_ckstep} * 48'd100;
  assign acc_sum_s  = {1'b0, acc_q} + {1'b0, step_q};
  assign tick_s     = (state_q == ST_RUN) && acc_sum_s[48];
  assign acc_d      = (state_q == ST_RUN) ? acc_sum_s[47:0] : acc_q;
  assign want_s     = tick_s || pend_q;
  assign load_val_s = i_load_value & VALUE_MASK;

  // A tick that lands while the precomputed decrement is stale is held one cycle.
  always_comb begin
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    state_d = state_q;
    alarm_d = alarm_q && !i_ack;
    int_d   = 1'b0;
    pend_d  = 1'b0;
    if (i_load) begin
      cnt_d   = load_val_s;
      rel_d   = load_val_s;
      alarm_d = 1'b0;
      if (load_val_s == 31'h0) begin
        state_d = ST_STOP;
      end else begin
        state_d = state_q;
      end
    end else if (i_stop) begin
      state_d = ST_STOP;
    end else begin
      if (i_start && (cnt_q != 31'h0)) begin
        state_d = ST_RUN;
      end else begin
        state_d = state_q;
      end
      if ((state_q == ST_RUN) && want_s) begin
        if (!dec_vld_q) begin
          pend_d = 1'b1;
        end else if (cnt_q == 31'h1) begin
          int_d   = 1'b1;
          alarm_d = 1'b1;
          if (OPT_AUTORELOAD && (rel_q != 31'h0)) begin
            cnt_d = rel_q;
          end else begin
            cnt_d   = 31'h0;
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = dec_q;
        end
      end else begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    step_q <= step_d;
    if (i_reset) begin
      state_q   <= ST_STOP;
      cnt_q     <= 31'h0;
      rel_q     <= 31'h0;
      dec_q     <= 31'h0;
      dec_vld_q <= 1'b0;
      pend_q    <= 1'b0;
      alarm_q   <= 1'b0;
      int_q     <= 1'b0;
      acc_q     <= 48'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      dec_q     <= bcd_dec(cnt_q);
      dec_vld_q <= (cnt_d == cnt_q);
      pend_q    <= pend_d;
      alarm_q   <= alarm_d;
      int_q     <= int_d;
      acc_q     <= acc_d;
    end
  end

  assign o_value   = cnt_q;
  assign o_running = (state_q == ST_RUN);
  assign o_alarm   = alarm_q;
  assign o_int     = int_q;

endmodule

// File: tb/tb_rtc_countdown_timer.sv
// Bench for rtc_countdown_timer: vector table plus corner sequences, both DUT variants.
module tb_rtc_countdown_timer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ld, start, stop, ack;
  logic [31:0] ckstep;
  logic [30:0] ldv;
  logic [30:0] val, val_ar;
  logic        run, run_ar, alarm, alarm_ar, intr, intr_ar;

  int n_chk = 0;
  int n_pass = 0;
  int int_cnt = 0;
  int int_cnt_ar = 0;

  rtc_countdown_timer #(.OPT_AUTORELOAD(1'b0)) dut (
    .i_clk(clk), .i_reset(rst), .i_ckstep(ckstep), .i_load(ld), .i_load_value(ldv),
    .i_start(start), .i_stop(stop), .i_ack(ack),
    .o_value(val), .o_running(run), .o_alarm(alarm), .o_int(intr));

  rtc_countdown_timer #(.OPT_AUTORELOAD(1'b1)) dut_ar (
    .i_clk(clk), .i_reset(rst), .i_ckstep(ckstep), .i_load(ld), .i_load_value(ldv),
    .i_start(start), .i_stop(stop), .i_ack(ack),
    .o_value(val_ar), .o_running(run_ar), .o_alarm(alarm_ar), .o_int(intr_ar));

  always @(negedge clk) begin
    if (intr) int_cnt++;
    if (intr_ar) int_cnt_ar++;
  end

  typedef struct {
    string       name;
    logic [30:0] val;
    logic        run;
    logic        alarm;
    logic        intr;
  } exp_t;

  typedef struct {
    string       name;
    logic [30:0] load_val;
    int          n_ticks;
    logic [30:0] exp_val;
    logic        exp_run;
    logic        exp_alarm;
    logic        exp_int;
  } vec_t;

  exp_t sb_q[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string n, input logic [30:0] v, input logic r,
                         input logic a, input logic i);
    exp_t e;
    e.name = n; e.val = v; e.run = r; e.alarm = a; e.intr = i;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic ar);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      if (ar) begin
        chk({e.name, "_value"}, {1'b0, val_ar}, {1'b0, e.val});
        chk({e.name, "_running"}, {31'h0, run_ar}, {31'h0, e.run});
        chk({e.name, "_alarm"}, {31'h0, alarm_ar}, {31'h0, e.alarm});
        chk({e.name, "_int"}, {31'h0, intr_ar}, {31'h0, e.intr});
      end else begin
        chk({e.name, "_value"}, {1'b0, val}, {1'b0, e.val});
        chk({e.name, "_running"}, {31'h0, run}, {31'h0, e.run});
        chk({e.name, "_alarm"}, {31'h0, alarm}, {31'h0, e.alarm});
        chk({e.name, "_int"}, {31'h0, intr}, {31'h0, e.intr});
      end
    end
  endtask

  task automatic wait_tick(input logic ar);
    logic [30:0] prev;
    logic        seen;
    prev = ar ? val_ar : val;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      cyc(1);
      if ((ar ? val_ar : val) !== prev) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL tick_timeout: got no change from %h expected change within 1000 cycles", prev);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [30:0] v);
    ld = 1'b1; ldv = v;
    cyc(1);
    ld = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  vec_t vecs[9];
  int   ic;
  logic held;

  initial begin
    rst = 1'b0; ld = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
    ckstep = 32'hFFFF_FFFF; ldv = 31'h0;

    vecs[0] = '{"v_3",       31'h0000_0003, 1, 31'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"v_1h",      31'h0100_0000, 1, 31'h0059_5999, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"v_150",     31'h0000_0150, 2, 31'h0000_0148, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"v_10s",     31'h0000_1000, 1, 31'h0000_0999, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"v_10min",   31'h0010_0000, 1, 31'h0009_5999, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"v_10hr",    31'h1000_0000, 1, 31'h0959_5999, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"v_expire",  31'h0000_0002, 2, 31'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{"v_tenths",  31'h0000_0101, 1, 31'h0000_0100, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{"v_mask",    31'h0080_8005, 1, 31'h0000_0004, 1'b1, 1'b0, 1'b0};

    cyc(2);
    do_reset();
    sb_push("reset", 31'h0, 1'b0, 1'b0, 1'b0);
    sb_check(1'b0);

    for (int k = 0; k < 9; k++) begin
      do_reset();
      do_load(vecs[k].load_val);
      do_start();
      sb_push(vecs[k].name, vecs[k].exp_val, vecs[k].exp_run, vecs[k].exp_alarm, vecs[k].exp_int);
      for (int t = 0; t < vecs[k].n_ticks; t++) wait_tick(1'b0);
      sb_check(1'b0);
    end

    // 3 -> 2 -> 1 -> 0 with a single interrupt cycle, then acknowledge
    do_reset();
    do_load(31'h3);
    do_start();
    wait_tick(1'b0);
    chk("seq3_first", {1'b0, val}, 32'h2);
    wait_tick(1'b0);
    chk("seq3_second", {1'b0, val}, 32'h1);
    ic = int_cnt;
    wait_tick(1'b0);
    sb_push("seq3_zero", 31'h0, 1'b0, 1'b1, 1'b1);
    sb_check(1'b0);
    cyc(1);
    chk("seq3_int_low", {31'h0, intr}, 32'h0);
    chk("seq3_int_count", ic, int_cnt - 1);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("seq3_ack", {31'h0, alarm}, 32'h0);

    // reset in the middle of a count
    do_load(31'h0000_0500);
    do_start();
    cyc(100);
    do_reset();
    sb_push("mid_reset", 31'h0, 1'b0, 1'b0, 1'b0);
    sb_check(1'b0);

    // stop holds the value, start resumes
    do_load(31'h0000_0150);
    do_start();
    wait_tick(1'b0);
    wait_tick(1'b0);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    ic = int_cnt;
    held = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      cyc(1);
      if (val !== 31'h0000_0148 || run !== 1'b0) held = 1'b0;
    end
    chk("stop_hold", {31'h0, held}, 32'h1);
    chk("stop_no_int", int_cnt, ic);
    do_start();
    wait_tick(1'b0);
    chk("resume_value", {1'b0, val}, 32'h0000_0147);

    // start with a zero counter is ignored; start+stop leaves it stopped
    do_reset();
    ic = int_cnt;
    do_start();
    cyc(2);
    chk("zero_start_run", {31'h0, run}, 32'h0);
    chk("zero_start_int", int_cnt, ic);
    do_load(31'h0000_0005);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_run", {31'h0, run}, 32'h0);

    // loading zero while running stops without an interrupt
    do_start();
    chk("run_before_zero_load", {31'h0, run}, 32'h1);
    ic = int_cnt;
    do_load(31'h0);
    cyc(1);
    sb_push("zero_load", 31'h0, 1'b0, 1'b0, 1'b0);
    sb_check(1'b0);
    chk("zero_load_int", int_cnt, ic);

    // autoreload: expiry reloads, keeps running, alarm set beats ack
    do_reset();
    do_load(31'h2);
    do_start();
    wait_tick(1'b1);
    chk("ar_first", {1'b0, val_ar}, 32'h1);
    ic = int_cnt_ar;
    ack = 1'b1;
    wait_tick(1'b1);
    ack = 1'b0;
    sb_push("ar_reload", 31'h2, 1'b1, 1'b1, 1'b1);
    sb_check(1'b1);
    cyc(1);
    chk("ar_int_low", {31'h0, intr_ar}, 32'h0);
    chk("ar_alarm_sticky", {31'h0, alarm_ar}, 32'h1);
    chk("ar_int_count", int_cnt_ar, ic + 1);
    wait_tick(1'b1);
    chk("ar_continue", {1'b0, val_ar}, 32'h1);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("ar_ack", {31'h0, alarm_ar}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
